// File: rtl/pixel_job_gen.sv
// Pixel job generator: walks an external column/row counter chain and emits one
// (x, y, c_re, c_im) job per pixel through a two-stage stallable pipeline.
module pixel_job_gen #(
    parameter int NX = 10,
    parameter int NY = 10,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  re_min,
    input  logic [W-1:0]  im_max,
    input  logic [W-1:0]  step,
    input  logic [NX-1:0] col_q,
    input  logic          col_tick,
    input  logic [NY-1:0] row_q,
    input  logic          row_tick,
    output logic          col_en,
    output logic          row_en,
    output logic          job_valid,
    input  logic          job_ready,
    output logic [NX-1:0] job_x,
    output logic [NY-1:0] job_y,
    output logic [W-1:0]  job_c_re,
    output logic [W-1:0]  job_c_im,
    output logic          job_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  re_min_q, im_max_q, step_q;

    logic          s1_valid_q, s1_last_q;
    logic [NX-1:0] s1_col_q;
    logic [NY-1:0] s1_row_q;

    logic          job_valid_q, job_last_q;
    logic [NX-1:0] job_x_q;
    logic [NY-1:0] job_y_q;
    logic [W-1:0]  job_c_re_q, job_c_im_q;
    logic          done_q;

    logic          pipe_adv;
    logic          frame_load;
    logic          last_capture;
    logic          final_hs;
    logic [W-1:0]  col_ext, row_ext;
    logic [W-1:0]  c_re_d, c_im_d;

    always_comb begin
        pipe_adv     = !job_valid_q || job_ready;
        col_en       = (state_q == RUN) && pipe_adv;
        row_en       = col_en && col_tick;
        frame_load   = (state_q == IDLE) && start;
        last_capture = col_en && col_tick && row_tick;
        final_hs     = (state_q == DRAIN) && job_valid_q && job_ready && job_last_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_load)   state_d = RUN;
            RUN:     if (last_capture) state_d = DRAIN;
            DRAIN:   if (final_hs)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Coordinates are formed in stage 2 from the captured indices; the W-bit
    // multiply keeps only the low bits, giving two's-complement wrap.
    always_comb begin
        col_ext = W'(s1_col_q);
        row_ext = W'(s1_row_q);
        c_re_d  = re_min_q + col_ext * step_q;
        c_im_d  = im_max_q - row_ext * step_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re_min_q <= '0;
            im_max_q <= '0;
            step_q   <= '0;
        end else if (frame_load) begin
            re_min_q <= re_min;
            im_max_q <= im_max;
            step_q   <= step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            job_valid_q <= 1'b0;
            job_last_q  <= 1'b0;
            job_x_q     <= '0;
            job_y_q     <= '0;
            job_c_re_q  <= '0;
            job_c_im_q  <= '0;
        end else if (pipe_adv) begin
            s1_valid_q  <= col_en;
            s1_last_q   <= col_tick && row_tick;
            s1_col_q    <= col_q;
            s1_row_q    <= row_q;
            job_valid_q <= s1_valid_q;
            job_last_q  <= s1_last_q;
            job_x_q     <= s1_col_q;
            job_y_q     <= s1_row_q;
            job_c_re_q  <= c_re_d;
            job_c_im_q  <= c_im_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= final_hs;
        end
    end

    assign job_valid = job_valid_q;
    assign job_last  = job_last_q;
    assign job_x     = job_x_q;
    assign job_y     = job_y_q;
    assign job_c_re  = job_c_re_q;
    assign job_c_im  = job_c_im_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_job_gen.sv
// Bench for pixel_job_gen paired with a 4-column x 3-row counter chain; jobs are
// compared against an index-arithmetic model of the frame.
module tb_pixel_job_gen;

    localparam int NX = 10;
    localparam int NY = 10;
    localparam int W  = 32;
    localparam int NCOL = 4;
    localparam int NROW = 3;
    localparam int NJOB = NCOL * NROW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  re_min = '0, im_max = '0, step = '0;
    logic [NX-1:0] col_q;
    logic [NY-1:0] row_q;
    logic          col_tick, row_tick;
    logic          col_en, row_en;
    logic          job_valid, job_last, busy, done;
    logic          job_ready = 1'b1;
    logic [NX-1:0] job_x;
    logic [NY-1:0] job_y;
    logic [W-1:0]  job_c_re, job_c_im;

    always #5 clk = ~clk;

    pixel_job_gen #(.NX(NX), .NY(NY), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .re_min(re_min), .im_max(im_max), .step(step),
        .col_q(col_q), .col_tick(col_tick), .row_q(row_q), .row_tick(row_tick),
        .col_en(col_en), .row_en(row_en),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_y(job_y), .job_c_re(job_c_re), .job_c_im(job_c_im),
        .job_last(job_last), .busy(busy), .done(done)
    );

    // Counter chain sharing the block's reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            if (col_en) col_q <= (col_q == NX'(NCOL - 1)) ? '0 : col_q + 1'b1;
            if (row_en) row_q <= (row_q == NY'(NROW - 1)) ? '0 : row_q + 1'b1;
        end
    end
    assign col_tick = (col_q == NX'(NCOL - 1));
    assign row_tick = (row_q == NY'(NROW - 1));

    typedef struct {
        int          x;
        int          y;
        logic [31:0] re;
        logic [31:0] im;
        bit          last;
        int          cyc;
    } job_t;

    job_t obs[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done, first_cyc, stall_viol, colen_viol;
    logic ab_valid, ab_busy;

    function automatic job_t model_job(int k, logic [31:0] re, logic [31:0] im, logic [31:0] st);
        job_t j;
        logic [31:0] xx, yy;
        j.x    = k % NCOL;
        j.y    = k / NCOL;
        xx     = 32'(j.x);
        yy     = 32'(j.y);
        j.re   = re + xx * st;
        j.im   = im - yy * st;
        j.last = (k == NJOB - 1);
        j.cyc  = 0;
        return j;
    endfunction

    // Drives one frame from the current negedge and records accepted jobs.
    task automatic run_frame(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st,
                             input int pct, input int poke_at, input int abort_after);
        logic [85:0] prev_snap, snap;
        bit          prev_stall;
        job_t        j;
        obs.delete();
        n_done = 0; first_cyc = -1; stall_viol = 0; colen_viol = 0;
        ab_valid = 1'bx; ab_busy = 1'bx;
        prev_stall = 0; prev_snap = '0;
        re_min = re; im_max = im; step = st; start = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (abort_after >= 0 && obs.size() == abort_after) begin
                reset = 1'b1;
                #1;
                ab_valid = job_valid;
                ab_busy  = busy;
                if (done) n_done++;
                break;
            end
            start = (cyc == poke_at);
            if (poke_at >= 0) begin
                re_min = $urandom; im_max = $urandom; step = $urandom;
            end
            job_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            #1;
            if (job_valid && first_cyc < 0) first_cyc = cyc;
            snap = {job_valid, job_x, job_y, job_c_re, job_c_im, job_last};
            if (prev_stall && snap !== prev_snap) stall_viol++;
            if (job_valid && !job_ready && col_en) colen_viol++;
            if (job_valid && job_ready) begin
                j.x = int'(job_x); j.y = int'(job_y); j.re = job_c_re; j.im = job_c_im;
                j.last = job_last; j.cyc = cyc;
                obs.push_back(j);
            end
            prev_stall = job_valid && !job_ready;
            prev_snap  = snap;
            if (done) begin
                n_done++;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({job_valid, busy, done, col_en} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags got %b expected 0000", {job_valid, busy, done, col_en}); end
        checks++; if ({job_x, job_y, job_c_re, job_c_im, job_last} !== '0) begin errors++;
            $display("FAIL reset_data got x=%0d y=%0d re=%h im=%h expected zeros", job_x, job_y, job_c_re, job_c_im); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({job_valid, busy, done} !== 3'b000) begin errors++;
            $display("FAIL idle_after_reset got %b expected 000", {job_valid, busy, done}); end
    endtask

    task automatic test_basic();
        job_t e;
        run_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 100, -1, -1);
        checks++; if (obs.size() != NJOB) begin errors++;
            $display("FAIL basic_count got %0d expected %0d", obs.size(), NJOB); end
        checks++; if (first_cyc != 2) begin errors++;
            $display("FAIL basic_latency got %0d expected 2", first_cyc); end
        for (int k = 0; k < obs.size() && k < NJOB; k++) begin
            e = model_job(k, 32'hE000_0000, 32'h1000_0000, 32'h0800_0000);
            checks++; if ({obs[k].x, obs[k].y, obs[k].re, obs[k].im, obs[k].last} !== {e.x, e.y, e.re, e.im, e.last}
                          || obs[k].cyc != 2 + k) begin errors++;
                $display("FAIL basic_job%0d got (%0d,%0d,%h,%h,%0d)@%0d expected (%0d,%0d,%h,%h,%0d)@%0d", k,
                         obs[k].x, obs[k].y, obs[k].re, obs[k].im, obs[k].last, obs[k].cyc,
                         e.x, e.y, e.re, e.im, e.last, 2 + k); end
        end
        if (obs.size() == NJOB) begin
            checks++; if ({obs[0].x, obs[0].y, obs[0].re, obs[0].im} !== {32'd0, 32'd0, 32'hE000_0000, 32'h1000_0000}) begin errors++;
                $display("FAIL basic_first got (%0d,%0d,%h,%h) expected (0,0,e0000000,10000000)", obs[0].x, obs[0].y, obs[0].re, obs[0].im); end
            checks++; if ({obs[11].x, obs[11].y, obs[11].re, obs[11].im, obs[11].last} !== {32'd3, 32'd2, 32'hF800_0000, 32'h0, 1'b1}) begin errors++;
                $display("FAIL basic_last got (%0d,%0d,%h,%h,%0d) expected (3,2,f8000000,00000000,1)", obs[11].x, obs[11].y, obs[11].re, obs[11].im, obs[11].last); end
        end
        checks++; if (n_done != 1) begin errors++;
            $display("FAIL basic_done got %0d expected 1", n_done); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL basic_busy_at_done got %b expected 0", busy); end
        @(negedge clk); #1;
        checks++; if ({done, busy, job_valid} !== 3'b000) begin errors++;
            $display("FAIL basic_after_done got %b expected 000", {done, busy, job_valid}); end
    endtask

    task automatic test_stall(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st, input int pct);
        job_t e;
        run_frame(re, im, st, pct, -1, -1);
        checks++; if (obs.size() != NJOB) begin errors++;
            $display("FAIL stall_count got %0d expected %0d", obs.size(), NJOB); end
        for (int k = 0; k < obs.size() && k < NJOB; k++) begin
            e = model_job(k, re, im, st);
            checks++; if ({obs[k].x, obs[k].y, obs[k].re, obs[k].im, obs[k].last} !== {e.x, e.y, e.re, e.im, e.last}) begin errors++;
                $display("FAIL stall_job%0d got (%0d,%0d,%h,%h,%0d) expected (%0d,%0d,%h,%h,%0d)", k,
                         obs[k].x, obs[k].y, obs[k].re, obs[k].im, obs[k].last, e.x, e.y, e.re, e.im, e.last); end
        end
        checks++; if (stall_viol != 0) begin errors++;
            $display("FAIL stall_stable got %0d changes expected 0", stall_viol); end
        checks++; if (colen_viol != 0) begin errors++;
            $display("FAIL stall_col_en got %0d enables expected 0", colen_viol); end
        checks++; if (n_done != 1) begin errors++;
            $display("FAIL stall_done got %0d expected 1", n_done); end
        @(negedge clk); #1;
    endtask

    task automatic test_start_busy();
        job_t e;
        run_frame(32'h1234_5678, 32'hF000_0001, 32'h0010_0003, 70, 6, -1);
        checks++; if (obs.size() != NJOB) begin errors++;
            $display("FAIL busy_start_count got %0d expected %0d", obs.size(), NJOB); end
        for (int k = 0; k < obs.size() && k < NJOB; k++) begin
            e = model_job(k, 32'h1234_5678, 32'hF000_0001, 32'h0010_0003);
            checks++; if ({obs[k].x, obs[k].y, obs[k].re, obs[k].im, obs[k].last} !== {e.x, e.y, e.re, e.im, e.last}) begin errors++;
                $display("FAIL busy_start_job%0d got (%0d,%0d,%h,%h) expected (%0d,%0d,%h,%h)", k,
                         obs[k].x, obs[k].y, obs[k].re, obs[k].im, e.x, e.y, e.re, e.im); end
        end
        checks++; if (n_done != 1) begin errors++;
            $display("FAIL busy_start_done got %0d expected 1", n_done); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({done, busy, job_valid} !== 3'b000) begin errors++;
            $display("FAIL busy_start_idle got %b expected 000", {done, busy, job_valid}); end
    endtask

    task automatic test_reset_mid();
        job_t e;
        run_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 100, -1, 5);
        checks++; if ({ab_valid, ab_busy} !== 2'b00) begin errors++;
            $display("FAIL abort_outputs got valid=%b busy=%b expected 0 0", ab_valid, ab_busy); end
        checks++; if (n_done != 0) begin errors++;
            $display("FAIL abort_done got %0d expected 0", n_done); end
        @(negedge clk);
        reset = 1'b0;
        run_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 100, -1, -1);
        checks++; if (obs.size() != NJOB) begin errors++;
            $display("FAIL abort_restart_count got %0d expected %0d", obs.size(), NJOB); end
        for (int k = 0; k < obs.size() && k < NJOB; k++) begin
            e = model_job(k, 32'hE000_0000, 32'h1000_0000, 32'h0800_0000);
            checks++; if ({obs[k].x, obs[k].y, obs[k].re, obs[k].im} !== {e.x, e.y, e.re, e.im}) begin errors++;
                $display("FAIL abort_restart_job%0d got (%0d,%0d,%h,%h) expected (%0d,%0d,%h,%h)", k,
                         obs[k].x, obs[k].y, obs[k].re, obs[k].im, e.x, e.y, e.re, e.im); end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_wrap();
        run_frame(32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 100, -1, -1);
        checks++; if (obs.size() != NJOB) begin errors++;
            $display("FAIL wrap_count got %0d expected %0d", obs.size(), NJOB); end
        if (obs.size() > 4) begin
            checks++; if (obs[1].re !== 32'hFFFF_FFFE) begin errors++;
                $display("FAIL wrap_re_col1 got %h expected fffffffe", obs[1].re); end
            checks++; if (obs[4].im !== 32'h8000_0001) begin errors++;
                $display("FAIL wrap_im_row1 got %h expected 80000001", obs[4].im); end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        job_t e;
        logic [31:0] re2, im2, st2;
        re2 = $urandom; im2 = $urandom; st2 = $urandom;
        run_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 100, -1, -1);
        checks++; if (n_done != 1) begin errors++;
            $display("FAIL b2b_first_done got %0d expected 1", n_done); end
        run_frame(re2, im2, st2, 100, -1, -1);
        checks++; if (obs.size() != NJOB || first_cyc != 2) begin errors++;
            $display("FAIL b2b_second got count=%0d first=%0d expected %0d and 2", obs.size(), first_cyc, NJOB); end
        for (int k = 0; k < obs.size() && k < NJOB; k++) begin
            e = model_job(k, re2, im2, st2);
            checks++; if ({obs[k].x, obs[k].y, obs[k].re, obs[k].im, obs[k].last} !== {e.x, e.y, e.re, e.im, e.last}) begin errors++;
                $display("FAIL b2b_job%0d got (%0d,%0d,%h,%h) expected (%0d,%0d,%h,%h)", k,
                         obs[k].x, obs[k].y, obs[k].re, obs[k].im, e.x, e.y, e.re, e.im); end
        end
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 50);
        test_stall($urandom, $urandom, $urandom, 60);
        test_start_busy();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
